// File: rtl/axis_frame_arbiter_if.sv
// rtl/axis_frame_arbiter_if.sv - stream bundle for the N-to-1 frame arbiter
// slave modport is the arbiter's view; master is the surrounding fabric's view.
interface axis_frame_arbiter_if #(
  parameter int N_PORTS = 4
);
  localparam int PW = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;

  logic [64*N_PORTS-1:0] s_axis_tdata;
  logic [8*N_PORTS-1:0]  s_axis_tkeep;
  logic [N_PORTS-1:0]    s_axis_tvalid;
  logic [N_PORTS-1:0]    s_axis_tlast;
  logic [N_PORTS-1:0]    s_axis_tready;
  logic [63:0]           m_axis_tdata;
  logic [7:0]            m_axis_tkeep;
  logic                  m_axis_tvalid;
  logic                  m_axis_tlast;
  logic                  m_axis_tready;
  logic [PW-1:0]         grant_port;
  logic                  busy;

  modport slave (
    input  s_axis_tdata, s_axis_tkeep, s_axis_tvalid, s_axis_tlast, m_axis_tready,
    output s_axis_tready, m_axis_tdata, m_axis_tkeep, m_axis_tvalid, m_axis_tlast,
    output grant_port, busy
  );

  modport master (
    output s_axis_tdata, s_axis_tkeep, s_axis_tvalid, s_axis_tlast, m_axis_tready,
    input  s_axis_tready, m_axis_tdata, m_axis_tkeep, m_axis_tvalid, m_axis_tlast,
    input  grant_port, busy
  );
endinterface

// File: rtl/axis_frame_arbiter.sv
// rtl/axis_frame_arbiter.sv - frame-granular round-robin merge of N 64-bit streams
// One IDLE cycle arbitrates each frame; XFER forwards the granted port until tlast.
module axis_frame_arbiter #(
  parameter int N_PORTS = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  axis_frame_arbiter_if.slave  bus
);
  localparam int PW = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;

  typedef enum logic {IDLE = 1'b0, XFER = 1'b1} state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [PW-1:0]     r_rr_ptr;
  logic [PW-1:0]     r_grant;
  logic [PW-1:0]     w_sel;
  logic              w_any;
  logic              w_load;
  logic              w_accept;
  logic [N_PORTS-1:0] w_tready;
  logic [63:0]       r_tdata;
  logic [7:0]        r_tkeep;
  logic              r_tvalid;
  logic              r_tlast;
  logic              r_busy;
  logic [63:0]       w_g_data;
  logic [7:0]        w_g_keep;
  logic              w_g_valid;
  logic              w_g_last;

  function automatic logic [PW-1:0] wrap_add(input logic [PW-1:0] base, input int k);
    int v;
    v = int'(base) + k;
    if (v >= N_PORTS) v = v - N_PORTS;
    return v[PW-1:0];
  endfunction

  // Scan downward so the port closest to rr_ptr is the one left in w_sel.
  always_comb begin
    logic [PW-1:0] idx;
    w_any = 1'b0;
    w_sel = r_rr_ptr;
    for (int k = N_PORTS - 1; k >= 0; k--) begin
      idx = wrap_add(r_rr_ptr, k);
      if (bus.s_axis_tvalid[idx]) begin
        w_any = 1'b1;
        w_sel = idx;
      end
    end
  end

  assign w_g_valid = bus.s_axis_tvalid[r_grant];
  assign w_g_last  = bus.s_axis_tlast[r_grant];
  assign w_g_data  = bus.s_axis_tdata[int'(r_grant)*64 +: 64];
  assign w_g_keep  = bus.s_axis_tkeep[int'(r_grant)*8 +: 8];

  always_comb begin
    w_state_nxt = r_state;
    w_tready    = '0;
    w_load      = bus.m_axis_tready | ~r_tvalid;
    w_accept    = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_any) w_state_nxt = XFER;
      end
      XFER: begin
        w_tready[r_grant] = w_load;
        w_accept = w_g_valid & w_load;
        if (w_accept && w_g_last) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= IDLE;
      r_rr_ptr <= '0;
      r_grant  <= '0;
      r_busy   <= 1'b0;
      r_tvalid <= 1'b0;
      r_tlast  <= 1'b0;
      r_tdata  <= '0;
      r_tkeep  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_busy  <= (w_state_nxt == XFER);
      if (r_state == IDLE && w_any) r_grant <= w_sel;
      if (w_accept && w_g_last) r_rr_ptr <= wrap_add(r_grant, 1);
      // Output register only moves when it is empty or being drained.
      if (w_load) begin
        r_tvalid <= w_accept;
        if (w_accept) begin
          r_tdata <= w_g_data;
          r_tkeep <= w_g_keep;
          r_tlast <= w_g_last;
        end
      end
    end
  end

  assign bus.s_axis_tready = w_tready;
  assign bus.m_axis_tdata  = r_tdata;
  assign bus.m_axis_tkeep  = r_tkeep;
  assign bus.m_axis_tvalid = r_tvalid;
  assign bus.m_axis_tlast  = r_tlast;
  assign bus.grant_port    = r_grant;
  assign bus.busy          = r_busy;
endmodule

// File: tb/tb_axis_frame_arbiter.sv
// tb/tb_axis_frame_arbiter.sv - directed and randomized checks of axis_frame_arbiter
// Random rounds compare the merged stream to a round-robin frame-order model.
module tb_axis_frame_arbiter;
  localparam int N = 4;

  typedef struct packed {
    logic [63:0] d;
    logic [7:0]  k;
    logic        l;
  } beat_t;

  logic clk;
  logic rst;
  int   n_cmp = 0;
  int   n_err = 0;

  beat_t src[N][$];
  beat_t rq[N][$];
  beat_t exp_q[$];
  bit    mid[N];

  axis_frame_arbiter_if #(.N_PORTS(N)) bus ();

  axis_frame_arbiter #(.N_PORTS(N)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic chk_out(input string tag, input logic [63:0] d, input logic [7:0] k, input logic l);
    chk(tag, {bus.m_axis_tvalid, bus.m_axis_tdata, bus.m_axis_tkeep, bus.m_axis_tlast},
        {1'b1, d, k, l});
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_tvalid"}, bus.m_axis_tvalid, 0);
    chk({tag, "_tlast"},  bus.m_axis_tlast, 0);
    chk({tag, "_tdata"},  bus.m_axis_tdata, 0);
    chk({tag, "_tkeep"},  bus.m_axis_tkeep, 0);
    chk({tag, "_grant"},  bus.grant_port, 0);
    chk({tag, "_busy"},   bus.busy, 0);
    chk({tag, "_tready"}, bus.s_axis_tready, 0);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int p, input logic v, input logic [63:0] d, input logic [7:0] k,
                       input logic l);
    bus.s_axis_tvalid[p]      = v;
    bus.s_axis_tdata[p*64 +: 64] = d;
    bus.s_axis_tkeep[p*8 +: 8]   = k;
    bus.s_axis_tlast[p]       = l;
  endtask

  task automatic clear_all();
    for (int p = 0; p < N; p++) drive(p, 1'b0, 64'h0, 8'h0, 1'b0);
  endtask

  // full=1: every port sends two 2-beat frames with no stalls, to measure bubbles.
  task automatic run_round(input bit full);
    beat_t b;
    int    nf, len, ptr, remaining, frames, total, cyc, first, last, pick;
    frames = 0;
    total  = 0;
    exp_q.delete();
    for (int p = 0; p < N; p++) begin
      src[p].delete();
      rq[p].delete();
      mid[p] = 1'b0;
      nf = full ? 2 : int'($urandom_range(0, 3));
      for (int f = 0; f < nf; f++) begin
        len = full ? 2 : int'($urandom_range(1, 4));
        for (int i = 0; i < len; i++) begin
          b.d = {$urandom, $urandom};
          b.k = 8'($urandom);
          b.l = (i == len - 1);
          src[p].push_back(b);
          rq[p].push_back(b);
          total++;
        end
        frames++;
      end
    end
    // Reference: after reset the pointer is 0; each frame goes to the next port
    // (cyclically) that still has frames, and the pointer moves just past it.
    ptr = 0;
    remaining = frames;
    while (remaining > 0) begin
      pick = -1;
      for (int k = 0; k < N && pick < 0; k++)
        if (rq[(ptr + k) % N].size() > 0) pick = (ptr + k) % N;
      do begin
        b = rq[pick].pop_front();
        exp_q.push_back(b);
      end while (!b.l);
      ptr = (pick + 1) % N;
      remaining--;
    end

    cyc = 0;
    first = -1;
    last = -1;
    while (exp_q.size() > 0 && cyc < 3000) begin
      for (int p = 0; p < N; p++) begin
        if (src[p].size() > 0) begin
          b = src[p][0];
          drive(p, !mid[p] || full || ($urandom_range(0, 3) != 0), b.d, b.k, b.l);
        end else begin
          drive(p, 1'b0, 64'h0, 8'h0, 1'b0);
        end
      end
      bus.m_axis_tready = full ? 1'b1 : ($urandom_range(0, 3) != 0);
      #1;
      if (bus.m_axis_tvalid && bus.m_axis_tready) begin
        b = exp_q.pop_front();
        chk_out("rnd_beat", b.d, b.k, b.l);
        if (first < 0) first = cyc;
        last = cyc;
      end
      for (int p = 0; p < N; p++) begin
        if (bus.s_axis_tvalid[p] && bus.s_axis_tready[p]) begin
          mid[p] = !src[p][0].l;
          void'(src[p].pop_front());
        end
      end
      step();
      cyc++;
    end
    chk("rnd_drain", exp_q.size(), 0);
    if (full) chk("rr_bubble_span", last - first + 1, total + frames - 1);
    clear_all();
    bus.m_axis_tready = 1'b1;
  endtask

  initial begin
    rst = 1'b1;
    bus.m_axis_tready = 1'b0;
    clear_all();
    step();
    step();
    chk_reset("reset");

    // Single requester on port 2, three-beat frame.
    rst = 1'b0;
    bus.m_axis_tready = 1'b1;
    drive(2, 1'b1, 64'hA0A0_0000_0000_0001, 8'hFF, 1'b0);
    #1;
    chk("idle_tready", bus.s_axis_tready, 0);
    chk("idle_busy", bus.busy, 0);
    step();
    chk("p2_grant", bus.grant_port, 2);
    chk("p2_busy", bus.busy, 1);
    chk("p2_tready", bus.s_axis_tready, 4'b0100);
    step();
    drive(2, 1'b1, 64'hA0A0_0000_0000_0002, 8'hFF, 1'b0);
    chk_out("p2_beat0", 64'hA0A0_0000_0000_0001, 8'hFF, 1'b0);
    step();
    drive(2, 1'b1, 64'hA0A0_0000_0000_0003, 8'h3F, 1'b1);
    chk_out("p2_beat1", 64'hA0A0_0000_0000_0002, 8'hFF, 1'b0);
    step();
    drive(2, 1'b0, 64'h0, 8'h0, 1'b0);
    chk_out("p2_beat2", 64'hA0A0_0000_0000_0003, 8'h3F, 1'b1);
    chk("p2_busy_end", bus.busy, 0);

    // Single-beat frames on ports 3 and 0; pointer now sits at 3.
    drive(3, 1'b1, 64'hC3C3_C3C3_C3C3_C3C3, 8'hF0, 1'b1);
    drive(0, 1'b1, 64'hC0C0_C0C0_C0C0_C0C0, 8'h0F, 1'b1);
    step();
    chk("sb_grant3", bus.grant_port, 3);
    chk("sb_bubble0", bus.m_axis_tvalid, 0);
    step();
    drive(3, 1'b0, 64'h0, 8'h0, 1'b0);
    chk_out("sb_p3", 64'hC3C3_C3C3_C3C3_C3C3, 8'hF0, 1'b1);
    step();
    chk("sb_grant0", bus.grant_port, 0);
    chk("sb_bubble1", bus.m_axis_tvalid, 0);
    step();
    drive(0, 1'b0, 64'h0, 8'h0, 1'b0);
    chk_out("sb_p0", 64'hC0C0_C0C0_C0C0_C0C0, 8'h0F, 1'b1);

    // Port 1 holds the grant while port 0 waits; downstream stalls mid-frame.
    drive(1, 1'b1, 64'hB1B1_0000_0000_0000, 8'hFF, 1'b0);
    drive(0, 1'b1, 64'hD0D0_D0D0_0000_0000, 8'hFF, 1'b1);
    step();
    chk("p1_grant", bus.grant_port, 1);
    chk("p1_tready", bus.s_axis_tready, 4'b0010);
    step();
    drive(1, 1'b1, 64'hB1B1_0000_0000_0001, 8'hFF, 1'b0);
    bus.m_axis_tready = 1'b0;
    #1;
    chk("stall_tready", bus.s_axis_tready, 0);
    chk_out("stall_b0", 64'hB1B1_0000_0000_0000, 8'hFF, 1'b0);
    for (int i = 0; i < 5; i++) begin
      step();
      chk_out("stall_hold", 64'hB1B1_0000_0000_0000, 8'hFF, 1'b0);
      chk("stall_hold_tready", bus.s_axis_tready, 0);
    end
    bus.m_axis_tready = 1'b1;
    #1;
    chk("unstall_tready", bus.s_axis_tready, 4'b0010);
    step();
    drive(1, 1'b1, 64'hB1B1_0000_0000_0002, 8'hFF, 1'b1);
    chk_out("p1_b1", 64'hB1B1_0000_0000_0001, 8'hFF, 1'b0);
    step();
    drive(1, 1'b0, 64'h0, 8'h0, 1'b0);
    chk_out("p1_b2", 64'hB1B1_0000_0000_0002, 8'hFF, 1'b1);
    #1;
    chk("p0_wait_tready", bus.s_axis_tready, 0);
    step();
    chk("p0_grant", bus.grant_port, 0);
    step();
    drive(0, 1'b0, 64'h0, 8'h0, 1'b0);
    chk_out("p0_d0", 64'hD0D0_D0D0_0000_0000, 8'hFF, 1'b1);

    // Reset after two beats of a four-beat frame on port 3.
    drive(3, 1'b1, 64'hE3E3_0000_0000_0000, 8'hFF, 1'b0);
    step();
    chk("e_grant3", bus.grant_port, 3);
    step();
    drive(3, 1'b1, 64'hE3E3_0000_0000_0001, 8'hFF, 1'b0);
    step();
    drive(3, 1'b1, 64'hE3E3_0000_0000_0002, 8'hFF, 1'b0);
    rst = 1'b1;
    step();
    chk_reset("midrst");
    rst = 1'b0;
    drive(2, 1'b1, 64'h2222, 8'hFF, 1'b1);
    drive(1, 1'b1, 64'h1111, 8'hFF, 1'b1);
    step();
    chk("postrst_grant", bus.grant_port, 1);
    rst = 1'b1;
    clear_all();
    step();

    // Full-load rotation, then randomized rounds.
    for (int r = 0; r < 6; r++) begin
      rst = 1'b1;
      step();
      rst = 1'b0;
      run_round(r == 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/axis_frame_arbiter.md
AXIS_FRAME_ARBITER -- requirements
Module: axis_frame_arbiter

Interface
REQ-001 The block SHALL have parameter N_PORTS, default 4, the number of input streams (2..8).
REQ-002 The block SHALL have a localparam PW = clog2(N_PORTS), minimum 1, the port index width.
REQ-003 clk  input  1  clock; all logic on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 s_axis_tdata  input  64*N_PORTS  port i data in bits [64i+63:64i].
REQ-006 s_axis_tkeep  input  8*N_PORTS  port i byte enables in bits [8i+7:8i].
REQ-007 s_axis_tvalid  input  N_PORTS  per-port valid.
REQ-008 s_axis_tlast  input  N_PORTS  per-port end of frame.
REQ-009 s_axis_tready  output  N_PORTS  per-port ready, combinational.
REQ-010 m_axis_tdata  output  64  merged data, registered.
REQ-011 m_axis_tkeep  output  8  merged byte enables, registered.
REQ-012 m_axis_tvalid  output  1  merged valid, registered.
REQ-013 m_axis_tlast  output  1  merged end of frame, registered.
REQ-014 m_axis_tready  input  1  downstream ready.
REQ-015 grant_port  output  PW  index of the currently or last granted port, registered.
REQ-016 busy  output  1  high while in XFER, registered.

Function
REQ-017 Arbitration SHALL be frame-granular: beats of different ports are never interleaved on m_axis.
REQ-018 The FSM SHALL have two states, IDLE and XFER.
REQ-019 IDLE SHALL move to XFER when any s_axis_tvalid is high.
- Grant: first port with tvalid high, searching upward from rr_ptr with wrap-around modulo N_PORTS.
- grant_port updates in the same cycle.
REQ-020 In IDLE, all s_axis_tready SHALL be 0.
REQ-021 The output stage SHALL be able to load when m_axis_tready=1 or m_axis_tvalid=0.
REQ-022 In XFER, s_axis_tready[grant_port] SHALL equal the output-stage load condition; all other tready bits SHALL be 0.
REQ-023 On an accepted beat (tvalid and tready of the granted port), the granted port's tdata/tkeep/tlast SHALL be loaded into the m_axis registers with m_axis_tvalid=1; latency is one cycle.
REQ-024 On a load cycle with no accepted beat, m_axis_tvalid SHALL be cleared; when not loading, all m_axis registers SHALL hold.
REQ-025 An accepted beat with tlast=1 SHALL move the FSM to IDLE and set rr_ptr to (grant_port+1) mod N_PORTS.
REQ-026 Each new frame SHALL cost exactly one IDLE arbitration cycle (one bubble between back-to-back frames).
REQ-027 tvalid of non-granted ports SHALL be ignored during XFER; those ports wait.
REQ-028 A granted port whose tvalid drops mid-frame SHALL keep its grant; no timeout.
REQ-029 A single-beat frame (tlast on first beat) SHALL be accepted in one XFER cycle, then the FSM returns to IDLE.
REQ-030 With all ports continuously requesting, grants SHALL rotate 0,1,...,N_PORTS-1,0,...

Reset
REQ-031 While rst=1, the block SHALL set: FSM=IDLE, rr_ptr=0, grant_port=0, busy=0, m_axis_tvalid=0, m_axis_tlast=0, m_axis_tdata=0, m_axis_tkeep=0, s_axis_tready=0.
REQ-032 Reset asserted mid-frame SHALL abort the frame; after reset, arbitration restarts from port 0.

Verification
REQ-033 Only port 2 requests, 3-beat frame, m_tready=1 -> IDLE 1 cycle, grant_port=2, 3 beats out in order, tlast on beat 3, rr_ptr=3.
REQ-034 All 4 ports send 2-beat frames continuously -> frame order 0,1,2,3,0; no interleaving; one bubble between frames.
REQ-035 m_tready held 0 for 5 cycles mid-frame -> m_axis held stable, granted tready=0, no beat lost or duplicated.
REQ-036 Port 1 in XFER while port 0 asserts tvalid -> port 0 tready stays 0 until port 1 tlast accepted, then port 0 is granted next (rr_ptr wraps 2->...->0).
REQ-037 rst pulsed after beat 2 of a 4-beat frame -> all outputs reach reset values next cycle; next grant is the lowest requesting port from 0.
REQ-038 Single-beat frames on ports 3 and 0 with rr_ptr=3 -> port 3 first, then port 0; each frame emitted with tlast=1 and keep preserved.
